// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: op codes, 17-bit opcode
// patterns, instruction word field positions and the word type.
package instr_pkg;

    typedef enum logic [3:0] {
        OP_MOV = 4'd0,
        OP_JMP = 4'd1,
        OP_CLR = 4'd2,
        OP_LDI = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_DIV = 4'd6,
        OP_MUL = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9
    } op_t;

    localparam logic [16:0] OPC_MOV = 17'b10000000010101010;
    localparam logic [16:0] OPC_JMP = 17'b10000001101010101;
    localparam logic [16:0] OPC_CLR = 17'b10000010011011011;
    localparam logic [16:0] OPC_LDI = 17'b10000011111111111;
    localparam logic [16:0] OPC_ADD = 17'b10000101101111100;
    localparam logic [16:0] OPC_SUB = 17'b10001011010101010;
    localparam logic [16:0] OPC_DIV = 17'b10000111000000001;
    localparam logic [16:0] OPC_MUL = 17'b10001000101111011;
    localparam logic [16:0] OPC_SHL = 17'b10001001011110110;
    localparam logic [16:0] OPC_SHR = 17'b10001010101110111;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 15;
    localparam int A_LO   = 10;
    localparam int B_LO   = 5;
    localparam int OPER_W = 5;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Host-side and memory-side handshake bundle of the instruction encoder.
// master = host/test driver, slave = encoder.
interface instr_encoder_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_a;
    logic [4:0]        in_b;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic [CNT_W-1:0]  count;
    logic              err_illegal;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, count, err_illegal
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_instr, out_addr, count, err_illegal
    );

endinterface

// File: rtl/instr_encoder_fifo.sv
// Show-ahead FIFO holding encoded words; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
    end

    // Stale storage is masked so the head reads zero whenever nothing is queued.
    assign head_data = empty ? '0 : mem[rd_ptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/instr_encoder.sv
// Packs symbolic instructions into 32-bit words tagged with a load address
// and queues them. Optional macro ENC_PARITY_EN: bit 0 becomes even parity.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);
    localparam int FIFO_W = 32 + ADDR_W;

    op_t               op;
    logic [16:0]       opcode;
    logic              legal;
    word_t             word;
    logic              accept;
    logic              push;
    logic              full;
    logic              empty;
    logic [FIFO_W-1:0] head;
    logic [ADDR_W-1:0] addr_ctr_reg;
    logic              err_reg;

    assign op = op_t'(bus.in_op);

    always_comb begin
        opcode = '0;
        legal  = 1'b1;
        case (op)
            OP_MOV:  opcode = OPC_MOV;
            OP_JMP:  opcode = OPC_JMP;
            OP_CLR:  opcode = OPC_CLR;
            OP_LDI:  opcode = OPC_LDI;
            OP_ADD:  opcode = OPC_ADD;
            OP_SUB:  opcode = OPC_SUB;
            OP_DIV:  opcode = OPC_DIV;
            OP_MUL:  opcode = OPC_MUL;
            OP_SHL:  opcode = OPC_SHL;
            OP_SHR:  opcode = OPC_SHR;
            default: legal  = 1'b0;
        endcase
    end

    always_comb begin
        word                       = '0;
        word[OPC_HI:OPC_LO]        = opcode;
        word[A_LO +: OPER_W]       = bus.in_a;
        word[B_LO +: OPER_W]       = bus.in_b;
`ifdef ENC_PARITY_EN
        word[0]                    = ^word[31:1];
`endif
    end

    // Illegal ops still complete the handshake; they just never reach the FIFO.
    assign accept = bus.in_valid && !full;
    assign push   = accept && legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_ctr_reg <= '0;
            err_reg      <= 1'b0;
        end else if (accept) begin
            if (legal) addr_ctr_reg <= addr_ctr_reg + 1'b1;
            else       err_reg      <= 1'b1;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({word, addr_ctr_reg}),
        .pop       (bus.out_ready),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (bus.count)
    );

    assign bus.in_ready    = !full;
    assign bus.out_valid   = !empty;
    assign bus.out_instr   = head[FIFO_W-1:ADDR_W];
    assign bus.out_addr    = head[ADDR_W-1:0];
    assign bus.err_illegal = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// address-wrap sequence and randomized traffic against a queue-based model.
module tb_instr_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam logic [31:0] ADD_3_7 = 32'h85BE0CE0;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    instr_encoder_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] word;
        logic [4:0]  addr;
    } ent_t;

    ent_t        q[$];
    int          m_addr = 0;
    logic        m_err  = 1'b0;
    logic [16:0] opc_tab [10];

    function automatic logic [31:0] ref_word(int op, int a, int b);
        logic [31:0] w;
        w = (32'(opc_tab[op]) << 15) + 32'(a * 1024) + 32'(b * 32);
`ifdef ENC_PARITY_EN
        if ($countones(w) % 2 == 1) w = w + 32'd1;
`endif
        return w;
    endfunction

    task automatic model_edge();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (reset) begin
            q.delete();
            m_addr = 0;
            m_err  = 1'b0;
        end else begin
            do_pop  = (q.size() > 0) && bus.out_ready;
            do_push = bus.in_valid && (q.size() < DEPTH);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (bus.in_op <= 4'd9) begin
                    e.word = ref_word(int'(bus.in_op), int'(bus.in_a), int'(bus.in_b));
                    e.addr = 5'(m_addr);
                    q.push_back(e);
                    m_addr = (m_addr + 1) % 32;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m_in_ready",  32'(bus.in_ready),    32'(q.size() < DEPTH));
        chk("m_out_valid", 32'(bus.out_valid),   32'(q.size() > 0));
        chk("m_count",     32'(bus.count),       32'(q.size()));
        chk("m_out_instr", bus.out_instr,        (q.size() > 0) ? q[0].word : 32'd0);
        chk("m_out_addr",  32'(bus.out_addr),    (q.size() > 0) ? 32'(q[0].addr) : 32'd0);
        chk("m_err",       32'(bus.err_illegal), 32'(m_err));
    endtask

    task automatic drive(logic r, logic iv, logic [3:0] op, logic [4:0] a, logic [4:0] b, logic ordy);
        reset         = r;
        bus.in_valid  = iv;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        model_check();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, iv;
        logic [3:0]  op;
        logic [4:0]  a, b;
        logic        ordy;
        logic        e_rdy, e_val;
        logic [2:0]  e_cnt;
        logic        ci;
        logic [31:0] e_instr;
        logic [4:0]  e_addr;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic iv, logic [3:0] op, logic [4:0] a, logic [4:0] b,
                                logic ordy, logic e_rdy, logic e_val, logic [2:0] e_cnt,
                                logic ci, logic [31:0] e_instr, logic [4:0] e_addr, logic e_err);
        vec_t v;
        v.rst = rst; v.iv = iv; v.op = op; v.a = a; v.b = b; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_cnt = e_cnt; v.ci = ci;
        v.e_instr = e_instr; v.e_addr = e_addr; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        opc_tab[0] = 17'b10000000010101010;
        opc_tab[1] = 17'b10000001101010101;
        opc_tab[2] = 17'b10000010011011011;
        opc_tab[3] = 17'b10000011111111111;
        opc_tab[4] = 17'b10000101101111100;
        opc_tab[5] = 17'b10001011010101010;
        opc_tab[6] = 17'b10000111000000001;
        opc_tab[7] = 17'b10001000101111011;
        opc_tab[8] = 17'b10001001011110110;
        opc_tab[9] = 17'b10001010101110111;

        //             rst iv op  a   b  ordy | rdy val cnt ci instr    addr err
        // reset held with in_valid=1
        vecs.push_back(mk(1, 1, 4,  3,  7, 0,   1, 0, 0, 1, 32'd0,   0, 0));
        vecs.push_back(mk(1, 1, 4,  3,  7, 0,   1, 0, 0, 1, 32'd0,   0, 0));
        // single ADD
        vecs.push_back(mk(0, 1, 4,  3,  7, 0,   1, 1, 1, 1, ADD_3_7, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0,   1, 0, 0, 1, 32'd0,   0, 0));
        // fill to DEPTH, fifth push held off
        vecs.push_back(mk(0, 1, 0,  0,  0, 0,   1, 1, 1, 0, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0,  1,  1, 0,   1, 1, 2, 0, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0,  2,  2, 0,   1, 1, 3, 0, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0,  3,  3, 0,   0, 1, 4, 0, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0,  4,  4, 0,   0, 1, 4, 0, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0,  4,  4, 1,   1, 1, 3, 0, 32'd0,   1, 0));
        vecs.push_back(mk(0, 1, 0,  4,  4, 1,   1, 1, 3, 0, 32'd0,   2, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 1,   1, 1, 2, 0, 32'd0,   3, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 1,   1, 1, 1, 0, 32'd0,   4, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 1,   1, 0, 0, 1, 32'd0,   0, 0));
        // illegal op between two MOVs
        vecs.push_back(mk(1, 0, 0,  0,  0, 0,   1, 0, 0, 1, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 0,  1,  2, 0,   1, 1, 1, 0, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 12, 5,  5, 0,   1, 1, 1, 0, 32'd0,   0, 1));
        vecs.push_back(mk(0, 1, 0,  3,  4, 0,   1, 1, 2, 0, 32'd0,   0, 1));
        vecs.push_back(mk(0, 0, 0,  0,  0, 1,   1, 1, 1, 0, 32'd0,   1, 1));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0,   1, 1, 1, 0, 32'd0,   1, 1));
        // simultaneous push/pop at count=2
        vecs.push_back(mk(0, 1, 1,  6,  7, 0,   1, 1, 2, 0, 32'd0,   1, 1));
        vecs.push_back(mk(0, 1, 2,  8,  9, 1,   1, 1, 2, 0, 32'd0,   2, 1));
        vecs.push_back(mk(0, 1, 3, 10, 11, 1,   1, 1, 2, 0, 32'd0,   3, 1));
        // reset mid-burst at count=3
        vecs.push_back(mk(0, 1, 5, 12, 13, 0,   1, 1, 3, 0, 32'd0,   3, 1));
        vecs.push_back(mk(1, 1, 4,  3,  7, 0,   1, 0, 0, 1, 32'd0,   0, 0));
        vecs.push_back(mk(0, 1, 4,  3,  7, 0,   1, 1, 1, 1, ADD_3_7, 0, 0));

        drive(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ordy);
            step();
            $display("vec %0d: rst=%0b iv=%0b op=%0d ordy=%0b -> rdy=%0b val=%0b cnt=%0d addr=%0d instr=%08h err=%0b",
                     i, vecs[i].rst, vecs[i].iv, vecs[i].op, vecs[i].ordy, bus.in_ready,
                     bus.out_valid, bus.count, bus.out_addr, bus.out_instr, bus.err_illegal);
            chk("v_in_ready",  32'(bus.in_ready),    32'(vecs[i].e_rdy));
            chk("v_out_valid", 32'(bus.out_valid),   32'(vecs[i].e_val));
            chk("v_count",     32'(bus.count),       32'(vecs[i].e_cnt));
            chk("v_out_addr",  32'(bus.out_addr),    32'(vecs[i].e_addr));
            chk("v_err",       32'(bus.err_illegal), 32'(vecs[i].e_err));
            if (vecs[i].ci) chk("v_out_instr", bus.out_instr, vecs[i].e_instr);
        end

        // address wrap: 33 legal pushes streamed straight through
        drive(1, 0, 0, 0, 0, 0);
        step();
        for (int k = 1; k <= 33; k++) begin
            drive(0, 1, 4'(k % 10), 5'(k), 5'(k + 3), 1);
            step();
            if (k == 32) chk("wrap_addr31", 32'(bus.out_addr), 32'd31);
        end
        $display("wrap: 33rd word addr=%0d count=%0d", bus.out_addr, bus.count);
        chk("wrap_addr0", 32'(bus.out_addr), 32'd0);
        chk("wrap_count", 32'(bus.count), 32'd1);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), rop,
                  5'($urandom), 5'($urandom), ($urandom_range(0, 9) < 6));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
